// File: rtl/noc_flit_tx.sv
// noc_flit_tx: drains a 1-cycle-latency flit FIFO into a 2-entry buffer feeding a valid/ready link, tracking packet framing.
module noc_flit_tx #(
  parameter int DATA_WIDTH = 37,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_flit,
  input  logic                  tx_ready,
  output logic                  in_packet,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic                  proto_err
);
  typedef enum logic {IDLE, IN_PKT} state_t;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;
  state_t state, state_n;
  logic [1:0] occ, base, ftype;
  logic [2:0] lvl;
  logic inflight, pop, cnt_inc, err_set;
  logic [DATA_WIDTH-1:0] slot0, slot1;
  assign pop        = tx_valid && tx_ready;
  // Count the flit still in the FIFO's read pipeline so the buffer can never overflow.
  assign lvl        = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign fifo_rd_en = tx_en && !fifo_empty && lvl < 3'd2;
  assign tx_valid   = occ != 2'd0;
  assign tx_flit    = slot0;
  assign base       = occ - {1'b0, pop};
  assign ftype      = tx_flit[DATA_WIDTH-1 -: 2];
  assign in_packet  = state == IN_PKT;
  always_comb begin
    state_n = !pop ? state : ftype == T_HEAD ? IN_PKT : ftype == T_BODY ? state : IDLE;
    cnt_inc = pop && (ftype == T_SINGLE || (ftype == T_TAIL && state == IN_PKT));
    err_set = pop && (state == IDLE ? (ftype == T_BODY || ftype == T_TAIL)
                                    : (ftype == T_HEAD || ftype == T_SINGLE));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ       <= '0;
      inflight  <= 1'b0;
      slot0     <= '0;
      slot1     <= '0;
      state     <= IDLE;
      pkt_cnt   <= '0;
      proto_err <= 1'b0;
    end else begin
      inflight  <= fifo_rd_en;
      occ       <= base + {1'b0, inflight};
      slot0     <= (inflight && base == 2'd0) ? fifo_data : pop ? slot1 : slot0;
      slot1     <= (inflight && base != 2'd0) ? fifo_data : slot1;
      state     <= state_n;
      pkt_cnt   <= pkt_cnt + CNT_WIDTH'(cnt_inc);
      proto_err <= proto_err | err_set;
    end
  end
endmodule

// File: tb/tb_noc_flit_tx.sv
// tb_noc_flit_tx: directed checks of noc_flit_tx against a behavioural 1-cycle-latency FIFO.
module tb_noc_flit_tx;
  localparam int DW = 37;
  logic clk = 0, rst = 1, tx_en = 0, tx_ready = 0;
  logic fifo_empty, fifo_rd_en, tx_valid, in_packet, proto_err;
  logic [DW-1:0] fifo_data, tx_flit;
  logic [15:0] pkt_cnt;
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] got [0:255];
  int wp = 0, rp = 0, ngot = 0, nrd = 0, viol = 0, occ_bad = 0;
  int errs = 0, checks = 0;
  logic load2 = 0, rd2, tv2, ip2, pe2;
  logic [DW-1:0] tf2;
  logic [3:0] pc2;
  int rem2 = 0;
  always #5 clk = ~clk;
  noc_flit_tx dut (.clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .tx_valid(tx_valid), .tx_flit(tx_flit),
    .tx_ready(tx_ready), .in_packet(in_packet), .pkt_cnt(pkt_cnt), .proto_err(proto_err));
  noc_flit_tx #(.CNT_WIDTH(4)) dut2 (.clk(clk), .rst(rst), .tx_en(1'b1), .fifo_empty(rem2 == 0),
    .fifo_rd_en(rd2), .fifo_data({2'b11, 35'h5}), .tx_valid(tv2), .tx_flit(tf2),
    .tx_ready(1'b1), .in_packet(ip2), .pkt_cnt(pc2), .proto_err(pe2));
  assign fifo_empty = (rp == wp);
  always @(posedge clk or posedge rst)
    if (rst) rp <= wp;
    else if (fifo_rd_en) begin
      fifo_data <= mem[rp[7:0]];
      rp <= rp + 1;
    end
  always @(posedge clk)
    if (load2) rem2 <= 17;
    else if (rd2) rem2 <= rem2 - 1;
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      got[ngot[7:0]] <= tx_flit;
      ngot <= ngot + 1;
    end
    if (fifo_rd_en) nrd <= nrd + 1;
    if (fifo_rd_en && fifo_empty) viol <= viol + 1;
    if (dut.occ > 2'd2) occ_bad <= occ_bad + 1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int p);
    return {t, 35'(p)};
  endfunction
  task automatic push(input logic [DW-1:0] f);
    mem[wp[7:0]] = f;
    wp = wp + 1;
  endtask
  initial begin
    logic [DW-1:0] f [0:3];
    logic [7:0] ev_rd, ev_v, ev_ip;
    int b, n0;
    repeat (2) step;
    chk("rst_valid", 64'(tx_valid), 0);
    chk("rst_rd", 64'(fifo_rd_en), 0);
    chk("rst_inpkt", 64'(in_packet), 0);
    chk("rst_cnt", 64'(pkt_cnt), 0);
    chk("rst_err", 64'(proto_err), 0);
    rst = 0;
    step;
    load2 = 1;
    step;
    load2 = 0;
    f[0] = mk(2'b01, 'h11); f[1] = mk(2'b00, 'h22); f[2] = mk(2'b00, 'h33); f[3] = mk(2'b10, 'h44);
    for (int i = 0; i < 4; i++) push(f[i]);
    b = ngot;
    ev_rd = 8'b00001111; ev_v = 8'b00111100; ev_ip = 8'b00111000;
    tx_ready = 1; tx_en = 1;
    #1;
    for (int c = 0; c < 8; c++) begin
      chk("t1_rd", 64'(fifo_rd_en), 64'(ev_rd[c]));
      chk("t1_valid", 64'(tx_valid), 64'(ev_v[c]));
      chk("t1_inpkt", 64'(in_packet), 64'(ev_ip[c]));
      if (ev_v[c]) chk("t1_flit", 64'(tx_flit), 64'(f[c-2]));
      step;
    end
    chk("t1_cnt", 64'(pkt_cnt), 1);
    chk("t1_err", 64'(proto_err), 0);
    chk("t1_ngot", 64'(ngot - b), 4);
    for (int i = 0; i < 4; i++) chk("t1_got", 64'(got[8'(b + i)]), 64'(f[i]));
    f[0] = mk(2'b01, 'h55); f[1] = mk(2'b00, 'h66); f[2] = mk(2'b00, 'h77); f[3] = mk(2'b10, 'h88);
    tx_ready = 0;
    for (int i = 0; i < 4; i++) push(f[i]);
    n0 = nrd; b = ngot;
    step; step;
    for (int c = 0; c < 3; c++) begin
      chk("t2_hold_valid", 64'(tx_valid), 1);
      chk("t2_hold_flit", 64'(tx_flit), 64'(f[0]));
      step;
    end
    chk("t2_stall_reads", 64'(nrd - n0), 2);
    tx_ready = 1;
    for (int i = 0; i < 20 && ngot - b < 4; i++) step;
    chk("t2_ngot", 64'(ngot - b), 4);
    for (int i = 0; i < 4; i++) chk("t2_got", 64'(got[8'(b + i)]), 64'(f[i]));
    step; step;
    chk("t2_cnt", 64'(pkt_cnt), 2);
    n0 = nrd; b = ngot;
    push(mk(2'b11, 'hAA));
    for (int c = 0; c < 6; c++) begin
      chk("t3_inpkt", 64'(in_packet), 0);
      step;
    end
    chk("t3_reads", 64'(nrd - n0), 1);
    chk("t3_cnt", 64'(pkt_cnt), 3);
    chk("t3_got", 64'(got[b[7:0]]), 64'(mk(2'b11, 'hAA)));
    b = ngot;
    f[0] = mk(2'b00, 'h1); f[1] = mk(2'b01, 'h2); f[2] = mk(2'b10, 'h3);
    for (int i = 0; i < 3; i++) push(f[i]);
    step; step;
    chk("t4_err_before", 64'(proto_err), 0);
    step;
    chk("t4_err_after", 64'(proto_err), 1);
    repeat (6) step;
    chk("t4_err_sticky", 64'(proto_err), 1);
    chk("t4_cnt", 64'(pkt_cnt), 4);
    chk("t4_inpkt", 64'(in_packet), 0);
    for (int i = 0; i < 3; i++) chk("t4_got", 64'(got[8'(b + i)]), 64'(f[i]));
    chk("t5_wrap_cnt", 64'(pc2), 1);
    chk("t5_err", 64'(pe2), 0);
    push(mk(2'b01, 'h90));
    for (int i = 1; i < 8; i++) push(mk(2'b00, 'h90 + i));
    repeat (4) step;
    chk("t6_pre_inpkt", 64'(in_packet), 1);
    chk("t6_pre_valid", 64'(tx_valid), 1);
    chk("t6_pre_inflight", 64'(dut.inflight), 1);
    rst = 1;
    step;
    chk("t6_valid", 64'(tx_valid), 0);
    chk("t6_rd", 64'(fifo_rd_en), 0);
    chk("t6_cnt", 64'(pkt_cnt), 0);
    chk("t6_err", 64'(proto_err), 0);
    chk("t6_inpkt", 64'(in_packet), 0);
    rst = 0;
    step;
    b = ngot;
    f[0] = mk(2'b01, 'h7); f[1] = mk(2'b10, 'h8);
    push(f[0]); push(f[1]);
    repeat (8) step;
    chk("t6_ngot", 64'(ngot - b), 2);
    for (int i = 0; i < 2; i++) chk("t6_got", 64'(got[8'(b + i)]), 64'(f[i]));
    chk("t6_cnt_after", 64'(pkt_cnt), 1);
    chk("t6_inpkt_after", 64'(in_packet), 0);
    chk("t6_err_after", 64'(proto_err), 0);
    chk("rd_while_empty", 64'(viol), 0);
    chk("occ_over_2", 64'(occ_bad), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
